// File: rtl/multu_unit.sv
// Sequential radix-2 shift-add unsigned multiplier that owns the HI/LO registers.
// One partial product per clock; stall holds MFHI/MFLO while a multiply is in flight.
module multu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      count;
    logic               last;
    logic               load;
    logic               finish;

    // The add keeps its carry so the shifted-in top bit is never lost.
    always_comb begin
        addend   = acc[0] ? mcand : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_step = {sum, acc[WIDTH-1:1]};
        last     = (count == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // HI/LO are only written on the final step, so partial sums never leak out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            acc   <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                mcand <= srca;
                acc   <= {{WIDTH{1'b0}}, srcb};
                count <= '0;
            end else if (state == RUN) begin
                acc   <= acc_step;
                count <= count + 1'b1;
                if (finish) begin
                    hi <= acc_step[2*WIDTH-1:WIDTH];
                    lo <= acc_step[WIDTH-1:0];
                end
            end
        end
    end

    assign busy  = (state == RUN);
    assign stall = rd_req & busy;

endmodule

// File: tb/tb_multu_unit.sv
// Scoreboard bench for multu_unit: directed operands with hand-computed products,
// a monitor pops expected {hi,lo} on every done pulse.
module tb_multu_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        rd_req;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared   = 0;
    int mismatched = 0;
    logic [63:0] sb[$];

    multu_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .srca   (srca),
        .srcb   (srcb),
        .rd_req (rd_req),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one start pulse; the expected product is queued only if the DUT should accept it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expected, input bit push);
        srca  = a;
        srcb  = b;
        start = 1'b1;
        if (push) sb.push_back(expected);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Observe one multiply until done, checking busy length, stall behaviour and HI/LO hold.
    task automatic waitDone(input string tag, input logic [63:0] prev,
                            input int expBusy, input int expStall);
        int busyCnt  = 0;
        int stallCnt = 0;
        bit holdOk   = 1'b1;
        bit seen     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busyCnt++;
            if (stall) stallCnt++;
            if ({hi, lo} !== prev) holdOk = 1'b0;
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({tag, "_busy_cycles"}, 64'(busyCnt), 64'(expBusy));
            checkOutput({tag, "_stall_cycles"}, 64'(stallCnt), 64'(expStall));
            checkOutput({tag, "_hold"}, 64'(holdOk), 64'd1);
            checkOutput({tag, "_stall_at_done"}, 64'(stall), 64'd0);
            checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                checkOutput("product", {hi, lo}, sb.pop_front());
            end
        end
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        srca   = '0;
        srcb   = '0;
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] small product 3*5");
        applyStimulus(32'd3, 32'd5, 64'h00000000_0000000F, 1'b1);
        waitDone("t1", 64'h0, 32, 0);

        $display("[TB] all-ones squared (carry path)");
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
        waitDone("t2", 64'h00000000_0000000F, 32, 0);

        $display("[TB] top-bit multiplicand, then zero multiplicand");
        applyStimulus(32'h80000000, 32'd2, 64'h00000001_00000000, 1'b1);
        waitDone("t3a", 64'hFFFFFFFE_00000001, 32, 0);
        applyStimulus(32'h0, 32'h12345678, 64'h0, 1'b1);
        waitDone("t3b", 64'h00000001_00000000, 32, 0);

        $display("[TB] rd_req held through the run");
        applyStimulus(32'hDEADBEEF, 32'h10, 64'h0000000D_EADBEEF0, 1'b1);
        rd_req = 1'b1;
        waitDone("t4", 64'h0, 32, 32);
        @(posedge clk);
        #1;
        rd_req = 1'b0;

        $display("[TB] async reset mid-run");
        applyStimulus(32'd7, 32'd9, 64'h0, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("t5_busy_after_reset", 64'(busy), 64'd0);
        checkOutput("t5_done_after_reset", 64'(done), 64'd0);
        checkOutput("t5_hilo_after_reset", {hi, lo}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(32'd4, 32'd4, 64'h10, 1'b1);
        waitDone("t5", 64'h0, 32, 0);

        $display("[TB] start in done cycle, starts while busy ignored");
        @(posedge clk);
        #1;
        applyStimulus(32'd6, 32'd7, 64'h2A, 1'b1);
        waitDone("t6a", 64'h10, 32, 0);
        applyStimulus(32'h00010001, 32'h00010001, 64'h00000001_00020001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(32'hFFFF, 32'hFFFF, 64'h0, 1'b0);
        end
        waitDone("t6b", 64'h2A, 29, 0);

        repeat (40) @(negedge clk);
        checkOutput("queue_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
